// File: rtl/cg_i2c_master_if.sv
// Command and bus-pin bundle for the coilgun I2C controller.
// The master modport is the controller's view; the slave modport is the host/bus side.
interface cg_i2c_master_if;
  logic        I_start;
  logic [6:0]  I_addr;
  logic        I_rw;
  logic [7:0]  I_wdata;
  logic [2:0]  I_nbytes;
  logic        I_sda;
  logic        O_sda;
  logic        OE_sda;
  logic        OE_scl;
  logic [31:0] O_rdata;
  logic        O_busy;
  logic        O_done;
  logic        O_nack;

  modport master (
    input  I_start, I_addr, I_rw, I_wdata, I_nbytes, I_sda,
    output O_sda, OE_sda, OE_scl, O_rdata, O_busy, O_done, O_nack
  );

  modport slave (
    output I_start, I_addr, I_rw, I_wdata, I_nbytes, I_sda,
    input  O_sda, OE_sda, OE_scl, O_rdata, O_busy, O_done, O_nack
  );
endinterface

// File: rtl/cg_i2c_master.sv
// I2C initiator for the coilgun board: single-byte register write, 1-4 byte read.
// Lines are driven open-drain through OE_sda/OE_scl; the pad ring builds the tristates.
//
// state       | meaning
// S_IDLE      | waiting for I_start, lines released
// S_START     | one slot generating the START condition
// S_ADDR      | 8 slots shifting out {addr, rw}
// S_ADDR_ACK  | SDA released, responder ACK sampled
// S_WDATA     | 8 slots shifting out the write byte
// S_WDATA_ACK | SDA released, responder ACK sampled
// S_RDATA     | SDA released, 8 bits shifted in
// S_RDATA_ACK | master ACK (more bytes) or NACK (last byte)
// S_STOP      | one slot generating the STOP condition
module cg_i2c_master #(
  parameter int CLK_DIV = 8
) (
  input  logic              I_clk,
  input  logic              I_rstn,
  cg_i2c_master_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
    S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_STOP
  } state_t;

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LD = DW'(CLK_DIV - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [2:0]      left_q, left_d;
  logic            samp_q, samp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            nack_q, nack_d;
  logic            done_q, done_d;
  logic            oe_sda_q, oe_sda_d;
  logic            oe_scl_q, oe_scl_d;

  logic            tick, slot_end, sample;

  // Line drive for a given slot position; returns {oe_scl, oe_sda}.
  function automatic logic [1:0] drive(state_t st, logic [1:0] qt, logic tx_bit, logic more);
    logic scl_low;
    scl_low = (qt < 2'd2);
    case (st)
      S_IDLE:             return 2'b00;
      S_START:            return {qt == 2'd3, qt >= 2'd2};
      S_STOP:             return {scl_low, qt != 2'd3};
      S_ADDR, S_WDATA:    return {scl_low, !tx_bit};
      S_RDATA_ACK:        return {scl_low, more};
      default:            return {scl_low, 1'b0};
    endcase
  endfunction

  // Next-state, datapath and registered pin-drive decode.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    left_d   = left_q;
    samp_d   = samp_q;
    rdata_d  = rdata_q;
    nack_d   = nack_q;
    done_d   = 1'b0;

    tick     = (div_q == '0);
    slot_end = tick && (qtr_q == 2'd3);
    sample   = tick && (qtr_q == 2'd2);

    if (state_q == S_IDLE) begin
      div_d = DIV_LD;
      qtr_d = 2'd0;
    end else begin
      div_d = tick ? DIV_LD : div_q - 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
      if (sample) samp_d = bus.I_sda;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.I_start) begin
          state_d = S_START;
          sh_d    = {bus.I_addr, bus.I_rw};
          rw_d    = bus.I_rw;
          wdata_d = bus.I_wdata;
          left_d  = (bus.I_nbytes == 3'd0) ? 3'd1 :
                    (bus.I_nbytes > 3'd4)  ? 3'd4 : bus.I_nbytes;
          rdata_d = '0;
          nack_d  = 1'b0;
        end
      end
      S_START: if (slot_end) begin
        state_d = S_ADDR;
        bit_d   = 3'd7;
      end
      S_ADDR, S_WDATA: if (slot_end) begin
        if (bit_q == 3'd0) begin
          state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WDATA_ACK;
        end else begin
          bit_d = bit_q - 3'd1;
          sh_d  = {sh_q[6:0], 1'b0};
        end
      end
      S_ADDR_ACK: if (slot_end) begin
        bit_d = 3'd7;
        if (samp_q) begin
          nack_d  = 1'b1;
          state_d = S_STOP;
        end else if (rw_q) begin
          state_d = S_RDATA;
        end else begin
          state_d = S_WDATA;
          sh_d    = wdata_q;
        end
      end
      S_WDATA_ACK: if (slot_end) begin
        if (samp_q) nack_d = 1'b1;
        state_d = S_STOP;
      end
      S_RDATA: begin
        if (sample) sh_d = {sh_q[6:0], bus.I_sda};
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            rdata_d = {rdata_q[23:0], sh_q};
            state_d = S_RDATA_ACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      S_RDATA_ACK: if (slot_end) begin
        if (left_q == 3'd1) begin
          state_d = S_STOP;
        end else begin
          left_d  = left_q - 3'd1;
          bit_d   = 3'd7;
          state_d = S_RDATA;
        end
      end
      S_STOP: if (slot_end) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are decoded from next-state values so the pads come straight off flops.
    {oe_scl_d, oe_sda_d} = drive(state_d, qtr_d, sh_d[7], left_d > 3'd1);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge I_clk) begin
    if (!I_rstn) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      sh_q     <= 8'd0;
      rw_q     <= 1'b0;
      wdata_q  <= 8'd0;
      left_q   <= 3'd0;
      samp_q   <= 1'b0;
      rdata_q  <= '0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      oe_sda_q <= 1'b0;
      oe_scl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      left_q   <= left_d;
      samp_q   <= samp_d;
      rdata_q  <= rdata_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      oe_sda_q <= oe_sda_d;
      oe_scl_q <= oe_scl_d;
    end
  end

  assign bus.O_sda   = 1'b0;
  assign bus.OE_sda  = oe_sda_q;
  assign bus.OE_scl  = oe_scl_q;
  assign bus.O_rdata = rdata_q;
  assign bus.O_busy  = (state_q != S_IDLE);
  assign bus.O_done  = done_q;
  assign bus.O_nack  = nack_q;

endmodule

// File: tb/tb_cg_i2c_master.sv
// Bench for cg_i2c_master: an I2C responder model decodes the bus and
// checks master bytes/ACKs against a scoreboard filled when commands are issued.
module tb_cg_i2c_master;
  localparam int CDIV = 2;

  logic I_clk = 1'b0;
  logic I_rstn = 1'b0;
  always #5 I_clk = ~I_clk;

  cg_i2c_master_if bus ();

  cg_i2c_master #(.CLK_DIV(CDIV)) dut (
    .I_clk  (I_clk),
    .I_rstn (I_rstn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        nack;
    int          busy;
  } res_t;

  logic [7:0] exp_byte[$];
  logic       exp_mack[$];
  res_t       exp_res[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Responder configuration, written by the stimulus process only.
  logic       nack_addr  = 1'b0;
  logic       nack_wdata = 1'b0;
  logic [7:0] rd_bytes[4];

  // Responder and monitor state, written by the monitor process only.
  logic resp_low = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic active = 1'b0, is_read = 1'b0, rd_done = 1'b0;
  logic [7:0] shift = 8'd0;
  int bitc = 0, byte_cnt = 0;
  int start_cnt = 0, stop_cnt = 0, busy_cnt = 0, done_cnt = 0;

  assign bus.I_sda = !(bus.OE_sda || resp_low);

  // Bus decode, responder drive and completion checks, sampled mid-cycle.
  always @(negedge I_clk) begin
    logic scl, sda;
    logic [7:0] nxt;
    res_t r;
    scl = !bus.OE_scl;
    sda = bus.I_sda;
    if (!I_rstn) begin
      active = 1'b0; bitc = 0; byte_cnt = 0; resp_low = 1'b0;
      start_cnt = 0; stop_cnt = 0; busy_cnt = 0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda) begin
        start_cnt++;
        active = 1'b1; bitc = 0; byte_cnt = 0; is_read = 1'b0; rd_done = 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        stop_cnt++;
        active = 1'b0;
      end else if (!prev_scl && scl && active) begin
        if (bitc < 8) begin
          nxt = {shift[6:0], sda};
          shift = nxt;
          if (bitc == 7 && (byte_cnt == 0 || !is_read)) begin
            if (byte_cnt == 0) is_read = nxt[0];
            if (exp_byte.size() == 0) chk("byte_extra", 32'(nxt), 32'hx);
            else chk("sda_byte", 32'(nxt), 32'(exp_byte.pop_front()));
          end
          bitc++;
        end else begin
          if (byte_cnt == 0 && sda) active = 1'b0;
          else if (is_read && byte_cnt >= 1) begin
            if (exp_mack.size() == 0) chk("mack_extra", 32'(!sda), 32'hx);
            else chk("master_ack", 32'(!sda), 32'(exp_mack.pop_front()));
            if (sda) rd_done = 1'b1;
          end
          bitc = 0;
          byte_cnt++;
        end
      end else if (prev_scl && !scl) begin
        if (!active) resp_low = 1'b0;
        else if (bitc == 8) resp_low = (byte_cnt == 0) ? !nack_addr : (!is_read ? !nack_wdata : 1'b0);
        else if (is_read && byte_cnt >= 1 && byte_cnt <= 4 && !rd_done) resp_low = !rd_bytes[byte_cnt-1][7-bitc];
        else resp_low = 1'b0;
      end

      if (bus.O_busy) busy_cnt++;
      if (bus.O_done) begin
        done_cnt++;
        if (exp_res.size() == 0) chk("done_extra", 32'd1, 32'd0);
        else begin
          r = exp_res.pop_front();
          chk("rdata", bus.O_rdata, r.rdata);
          chk("nack", 32'(bus.O_nack), 32'(r.nack));
          chk("busy_cycles", 32'(busy_cnt), 32'(r.busy));
          chk("busy_at_done", 32'(bus.O_busy), 32'd0);
          chk("start_cond", 32'(start_cnt), 32'd1);
          chk("stop_cond", 32'(stop_cnt), 32'd1);
        end
        busy_cnt = 0; start_cnt = 0; stop_cnt = 0;
      end
    end
    prev_scl = scl;
    prev_sda = bus.I_sda;
  end

  task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic [2:0] nb, input logic na, input logic nw,
                         input logic [31:0] rb, input logic dup);
    res_t r;
    int slots, n, d0;
    logic got;
    nack_addr  = na;
    nack_wdata = nw;
    for (int i = 0; i < 4; i++) rd_bytes[i] = rb[31-8*i -: 8];
    exp_byte.push_back({a, rw});
    r.rdata = '0;
    r.nack  = 1'b0;
    if (na) begin
      slots  = 11;
      r.nack = 1'b1;
    end else if (!rw) begin
      exp_byte.push_back(wd);
      slots  = 20;
      r.nack = nw;
    end else begin
      n = (nb == 3'd0) ? 1 : ((nb > 3'd4) ? 4 : int'(nb));
      slots = 11 + 9 * n;
      for (int i = 0; i < n; i++) begin
        r.rdata = {r.rdata[23:0], rd_bytes[i]};
        exp_mack.push_back(i < n - 1);
      end
    end
    r.busy = slots * 4 * CDIV;
    exp_res.push_back(r);

    @(posedge I_clk); #1;
    bus.I_addr = a; bus.I_rw = rw; bus.I_wdata = wd; bus.I_nbytes = nb;
    bus.I_start = 1'b1;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge I_clk); #1;
      bus.I_start = dup && (i == 40);
      if (dup && i == 40) begin
        bus.I_addr = a ^ 7'h55; bus.I_rw = !rw; bus.I_wdata = ~wd;
      end
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge I_clk);
  endtask

  initial begin
    int d0;
    logic seen;
    bus.I_start = 1'b0; bus.I_addr = '0; bus.I_rw = 1'b0; bus.I_wdata = '0; bus.I_nbytes = '0;
    repeat (3) @(posedge I_clk);
    #1;
    chk("rst_oe_sda", 32'(bus.OE_sda), 32'd0);
    chk("rst_oe_scl", 32'(bus.OE_scl), 32'd0);
    chk("rst_busy",   32'(bus.O_busy), 32'd0);
    chk("rst_done",   32'(bus.O_done), 32'd0);
    chk("rst_nack",   32'(bus.O_nack), 32'd0);
    chk("rst_rdata",  bus.O_rdata, 32'd0);
    chk("rst_o_sda",  32'(bus.O_sda), 32'd0);
    I_rstn = 1'b1;
    repeat (2) @(posedge I_clk);

    run_cmd(7'h02, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cmd(7'h2A, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 32'hAA0F0F0F, 1'b0);
    run_cmd(7'h33, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0);
    run_cmd(7'h2A, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 32'h5C000000, 1'b0);
    run_cmd(7'h2A, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 32'h11223344, 1'b0);
    run_cmd(7'h41, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 32'h817E0000, 1'b0);
    run_cmd(7'h50, 1'b0, 8'h3E, 3'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    // Reset during the third address bit.
    nack_addr = 1'b0; nack_wdata = 1'b0;
    @(posedge I_clk); #1;
    bus.I_addr = 7'h3C; bus.I_rw = 1'b0; bus.I_wdata = 8'h5A; bus.I_start = 1'b1;
    @(posedge I_clk); #1;
    bus.I_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge I_clk);
      if (active && bitc == 2) begin seen = 1'b1; break; end
    end
    chk("reach_bit3", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge I_clk);
      if (bus.OE_scl) begin seen = 1'b1; break; end
    end
    chk("reach_bit3_low", 32'(seen), 32'd1);
    @(posedge I_clk); #1;
    I_rstn = 1'b0;
    d0 = done_cnt;
    @(posedge I_clk); #1;
    I_rstn = 1'b1;
    chk("mid_rst_oe_sda", 32'(bus.OE_sda), 32'd0);
    chk("mid_rst_oe_scl", 32'(bus.OE_scl), 32'd0);
    chk("mid_rst_busy",   32'(bus.O_busy), 32'd0);
    repeat (300) @(posedge I_clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'(d0));

    run_cmd(7'h3C, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cmd(7'h11, 1'b0, 8'h96, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);

    chk("exp_left", 32'(exp_byte.size() + exp_mack.size() + exp_res.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
